// File: rtl/rca_result_collector_pkg.sv
// Shared configuration for the RCA result-collection path.
//
// Contents:
//   - rca_collect_state_t: collector FSM states (IDLE/COLLECT/DRAIN).
//   - RCA_COLLECT_TIMEOUT: COLLECT watchdog limit, in cycles. It is only used
//     when RCA_COLLECT_TIMEOUT_EN is defined.
//   - NUM_IO: default number of grid IO blocks, taken from the grid IO count.
package rca_config;

  localparam int RCA_GRID_IO_COUNT   = 4;
  localparam int NUM_IO              = RCA_GRID_IO_COUNT;
  localparam int RCA_COLLECT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } rca_collect_state_t;

endpackage

// File: rtl/rca_result_collector_lowest_bit_sel.sv
// rca_lowest_bit_sel: priority encoder over a pending-bit vector.
// Kept generic so the RCA control unit can reuse it.
//
// Ports:
//   pend_i   [N]     pending bits
//   idx_o    [IDX_W] index of the lowest set bit (0 when none is set)
//   onehot_o [N]     one-hot of the lowest set bit (0 when none is set)
//   single_o         exactly one bit of pend_i is set
module rca_lowest_bit_sel #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pend_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     onehot_o,
  output logic             single_o
);

  logic found;

  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pend_i[i] && !found) begin
        found       = 1'b1;
        idx_o       = IDX_W'(i);
        onehot_o[i] = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a power of two.
  assign single_o = (pend_i != '0) && ((pend_i & (pend_i - N'(1))) == '0);

endmodule

// File: rtl/rca_result_collector.sv
// rca_result_collector: waits until every selected grid IO FIFO holds a word,
// pops all of them in one cycle, then hands the words to writeback one at a
// time (lowest IO index first) over a valid/ack handshake. It signals
// completion with the launch instruction ID.
//
// Optional feature: define RCA_COLLECT_TIMEOUT_EN to add a COLLECT watchdog.
// The watchdog sets the sticky timeout_err and returns to IDLE without done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, start_id, out_mask   launch request (sampled in IDLE only)
//   flush                       synchronous abort to IDLE
//   io_valid, io_data, io_pop   grid IO FIFO heads and pops
//   wb_valid, wb_data, wb_idx,
//   wb_last, wb_ack             writeback handshake
//   done, done_id               completion pulse and its instruction ID
//   busy                        FSM not in IDLE
//   timeout_err                 sticky watchdog error
module rca_result_collector #(
  parameter int   NUM_IO = rca_config::NUM_IO,
  parameter int   XLEN   = 32,
  parameter int   ID_W   = 2,
  localparam int  IDX_W  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ID_W-1:0]        start_id,
  input  logic [NUM_IO-1:0]      out_mask,
  input  logic                   flush,
  input  logic [NUM_IO-1:0]      io_valid,
  input  logic [NUM_IO*XLEN-1:0] io_data,
  output logic [NUM_IO-1:0]      io_pop,
  output logic                   wb_valid,
  output logic [XLEN-1:0]        wb_data,
  output logic [IDX_W-1:0]       wb_idx,
  output logic                   wb_last,
  input  logic                   wb_ack,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   busy,
  output logic                   timeout_err
);

  import rca_config::*;

  rca_collect_state_t state_q;
  logic [NUM_IO-1:0]  mask_q;
  logic [NUM_IO-1:0]  pend_q;
  logic [ID_W-1:0]    id_q;
  logic [XLEN-1:0]    buf_q [NUM_IO];
  logic               done_zero_q;  // empty-mask launch completes next cycle

  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_IO-1:0]  sel_onehot;
  logic               sel_single;
  logic               capture;
  logic               drain_done;

  rca_lowest_bit_sel #(.N(NUM_IO), .IDX_W(IDX_W)) u_sel (
    .pend_i   (pend_q),
    .idx_o    (sel_idx),
    .onehot_o (sel_onehot),
    .single_o (sel_single)
  );

  // io_pop depends only on state, mask_q and io_valid (and flush); never on wb_ack.
  assign capture    = (state_q == COLLECT) && ((io_valid & mask_q) == mask_q) && !flush;
  assign io_pop     = capture ? mask_q : '0;

  assign wb_valid   = (state_q == DRAIN);
  assign wb_idx     = wb_valid ? sel_idx : '0;
  assign wb_data    = wb_valid ? buf_q[sel_idx] : '0;
  assign wb_last    = wb_valid && sel_single;

  assign drain_done = wb_valid && wb_ack && sel_single && !flush;
  assign done       = !flush && (done_zero_q || drain_done);
  assign done_id    = done ? id_q : '0;
  assign busy       = (state_q != IDLE);

`ifdef RCA_COLLECT_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      pend_q      <= '0;
      id_q        <= '0;
      done_zero_q <= 1'b0;
      for (int i = 0; i < NUM_IO; i++) buf_q[i] <= '0;
`ifdef RCA_COLLECT_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_zero_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        pend_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mask_q <= out_mask;
              id_q   <= start_id;
              if (out_mask != '0) begin
                state_q <= COLLECT;
`ifdef RCA_COLLECT_TIMEOUT_EN
                cnt_q   <= '0;
`endif
              end else begin
                done_zero_q <= 1'b1;
              end
            end
          end
          COLLECT: begin
            if (capture) begin
              for (int i = 0; i < NUM_IO; i++) begin
                if (mask_q[i]) buf_q[i] <= io_data[i*XLEN +: XLEN];
              end
              pend_q  <= mask_q;
              state_q <= DRAIN;
            end
`ifdef RCA_COLLECT_TIMEOUT_EN
            // cnt_q counts COLLECT cycles already spent; the limit-th one aborts.
            else if (cnt_q == 16'(RCA_COLLECT_TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
`endif
          end
          DRAIN: begin
            if (wb_ack) begin
              pend_q <= pend_q & ~sel_onehot;
              if (sel_single) state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rca_result_collector.sv
module tb_rca_result_collector;

  localparam int NIO  = 4;
  localparam int XL   = 32;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IDW-1:0]  start_id;
  logic [NIO-1:0]  out_mask;
  logic            flush;
  logic [NIO-1:0]  io_valid;
  logic [NIO*XL-1:0] io_data;
  logic [NIO-1:0]  io_pop;
  logic            wb_valid;
  logic [XL-1:0]   wb_data;
  logic [1:0]      wb_idx;
  logic            wb_last;
  logic            wb_ack;
  logic            done;
  logic [IDW-1:0]  done_id;
  logic            busy;
  logic            timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural FIFO model standing in for the grid IO blocks.
  logic [XL-1:0] fq [NIO][$];

  always #5 clk = ~clk;

  rca_result_collector #(.NUM_IO(NIO), .XLEN(XL), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_id(start_id),
    .out_mask(out_mask), .flush(flush), .io_valid(io_valid), .io_data(io_data),
    .io_pop(io_pop), .wb_valid(wb_valid), .wb_data(wb_data), .wb_idx(wb_idx),
    .wb_last(wb_last), .wb_ack(wb_ack), .done(done), .done_id(done_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_io();
    for (int i = 0; i < NIO; i++) begin
      io_valid[i] = (fq[i].size() > 0);
      io_data[i*XL +: XL] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NIO; i++) fq[i].delete();
    refresh_io();
  endtask

  // Advance one clock: apply pops seen this cycle, then land mid-cycle.
  task automatic cycle();
    logic [NIO-1:0] p;
    p = io_pop;
    @(posedge clk);
    for (int i = 0; i < NIO; i++) if (p[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    #1;
    refresh_io();
    @(negedge clk);
  endtask

  task automatic chk_occupancy(input logic [NIO-1:0] exp_nonempty);
    logic [NIO-1:0] occ;
    for (int i = 0; i < NIO; i++) occ[i] = (fq[i].size() > 0);
    chk("fifo_occupancy", occ, exp_nonempty);
  endtask

  // One full collection. ack_mode: 0 = ack tied high, 1 = random stalls,
  // 2 = ack low for 3 cycles on every word. Bits in 'late' get their word
  // only after late_cyc COLLECT cycles.
  task automatic run_collect(input logic [NIO-1:0] mask, input logic [IDW-1:0] id,
                             input int ack_mode, input logic [NIO-1:0] late, input int late_cyc);
    int             exp_idx[$];
    logic [XL-1:0]  exp_dat[$];
    int             hold;
    for (int i = 0; i < NIO; i++) if (!late[i]) fq[i].push_back($urandom);
    refresh_io();
    start = 1'b1; start_id = id; out_mask = mask; wb_ack = 1'b0;
    #1;
    chk("start_cycle_busy", busy, 1'b0);
    chk("start_cycle_done", done, 1'b0);
    cycle();
    start = 1'b0; start_id = IDW'($urandom); out_mask = NIO'($urandom);
    wb_ack = 1'b0;
    #1;
    if (mask == '0) begin
      chk("zero_mask_done", done, 1'b1);
      chk("zero_mask_done_id", done_id, id);
      chk("zero_mask_busy", busy, 1'b0);
      chk("zero_mask_pop", io_pop, '0);
      cycle();
      #1;
      chk("zero_mask_done_once", done, 1'b0);
      chk("zero_mask_busy_after", busy, 1'b0);
      chk_occupancy(~mask);
    end else begin
      for (int k = 0; k < late_cyc; k++) begin
        wb_ack = $urandom_range(0, 1);
        #1;
        chk("wait_no_pop", io_pop, '0);
        chk("wait_busy", busy, 1'b1);
        chk("wait_wb_valid", wb_valid, 1'b0);
        chk("wait_done", done, 1'b0);
        cycle();
      end
      for (int i = 0; i < NIO; i++) if (late[i]) fq[i].push_back($urandom);
      refresh_io();
      wb_ack = $urandom_range(0, 1);
      #1;
      for (int i = 0; i < NIO; i++) begin
        if (mask[i]) begin
          exp_idx.push_back(i);
          exp_dat.push_back(fq[i][0]);
        end
      end
      chk("capture_pop", io_pop, mask);
      chk("capture_wb_valid", wb_valid, 1'b0);
      cycle();
      while (exp_idx.size() > 0) begin
        hold = (ack_mode == 0) ? 0 : (ack_mode == 2) ? 3 : $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
          wb_ack = 1'b0;
          #1;
          chk("stall_valid", wb_valid, 1'b1);
          chk("stall_idx", wb_idx, exp_idx[0]);
          chk("stall_data", wb_data, exp_dat[0]);
          chk("stall_last", wb_last, exp_idx.size() == 1);
          chk("stall_done", done, 1'b0);
          chk("stall_pop", io_pop, '0);
          cycle();
        end
        wb_ack = 1'b1;
        #1;
        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_idx", wb_idx, exp_idx[0]);
        chk("wb_data", wb_data, exp_dat[0]);
        chk("wb_last", wb_last, exp_idx.size() == 1);
        chk("wb_done", done, exp_idx.size() == 1);
        if (exp_idx.size() == 1) chk("wb_done_id", done_id, id);
        chk("drain_pop", io_pop, '0);
        cycle();
        void'(exp_idx.pop_front());
        void'(exp_dat.pop_front());
      end
      wb_ack = 1'b0;
      #1;
      chk("post_busy", busy, 1'b0);
      chk("post_wb_valid", wb_valid, 1'b0);
      chk("post_done", done, 1'b0);
      chk_occupancy(~mask);
    end
    clear_fifos();
  endtask

  initial begin
    logic [XL-1:0] w0, w1, w3;
    logic [NIO-1:0] m, lt;
    rst_n = 1'b0; start = 1'b0; start_id = '0; out_mask = '0; flush = 1'b0; wb_ack = 1'b0;
    clear_fifos();
    repeat (2) @(negedge clk);
    chk("rst_io_pop", io_pop, '0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_wb_idx", wb_idx, '0);
    chk("rst_wb_last", wb_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_id", done_id, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    cycle();

    // Two-word collection, ack tied high.
    run_collect(4'b0101, 2'd2, 0, 4'b0000, 0);
    // IO3 arrives five cycles late.
    run_collect(4'b1111, 2'd3, 0, 4'b1000, 5);
    // Ack held low three cycles per word.
    run_collect(4'b1011, 2'd0, 2, 4'b0000, 0);
    // Empty mask completes immediately.
    run_collect(4'b0000, 2'd1, 0, 4'b0000, 0);

    // Flush in DRAIN after the first of three words.
    w0 = $urandom; w1 = $urandom; w3 = $urandom;
    fq[0].push_back(w0); fq[1].push_back(w1); fq[3].push_back(w3);
    refresh_io();
    start = 1'b1; start_id = 2'd3; out_mask = 4'b1011;
    cycle();
    start = 1'b0;
    #1;
    chk("fl_capture_pop", io_pop, 4'b1011);
    cycle();
    wb_ack = 1'b1;
    #1;
    chk("fl_first_idx", wb_idx, 2'd0);
    chk("fl_first_data", wb_data, w0);
    chk("fl_first_done", done, 1'b0);
    cycle();
    wb_ack = 1'b0; flush = 1'b1;
    #1;
    chk("fl_second_idx", wb_idx, 2'd1);
    chk("fl_second_data", wb_data, w1);
    chk("fl_flush_done", done, 1'b0);
    chk("fl_flush_pop", io_pop, '0);
    cycle();
    flush = 1'b0;
    #1;
    chk("fl_after_busy", busy, 1'b0);
    chk("fl_after_wb_valid", wb_valid, 1'b0);
    chk("fl_after_done", done, 1'b0);
    clear_fifos();
    run_collect(4'b0110, 2'd2, 0, 4'b0000, 0);

    // Randomised collections.
    for (int t = 0; t < 25; t++) begin
      m  = NIO'($urandom);
      lt = m & NIO'($urandom);
      run_collect(m, IDW'($urandom), 1, lt, (lt != '0) ? $urandom_range(1, 4) : 0);
    end

`ifdef RCA_COLLECT_TIMEOUT_EN
    // No IO ever becomes valid: watchdog fires after 1024 COLLECT cycles.
    clear_fifos();
    start = 1'b1; start_id = 2'd1; out_mask = 4'b0001;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      #1;
      chk("to_busy", busy, 1'b1);
      chk("to_err_early", timeout_err, 1'b0);
      chk("to_done", done, 1'b0);
      cycle();
    end
    #1;
    chk("to_err_set", timeout_err, 1'b1);
    chk("to_busy_drop", busy, 1'b0);
    chk("to_done_after", done, 1'b0);
    run_collect(4'b0011, 2'd2, 0, 4'b0000, 0);
    chk("to_err_sticky", timeout_err, 1'b1);
`else
    chk("no_timeout_err", timeout_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
